// File: rtl/ff_d_pipe.sv
// ff_d_pipe: WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid
// bit and a valid/ready handshake at both ends. Bubbles collapse under
// back-pressure. FLUSH synchronously clears the pipeline. OCC reports how
// many stages are valid.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   EN         global enable; 0 freezes every stage
//   FLUSH      synchronous clear of all valid bits
//   IN_VALID   D carries a word
//   IN_READY   pipeline accepts D this cycle (combinational take chain)
//   D          input word
//   OUT_VALID  Q carries a word (valid bit of the last stage)
//   OUT_READY  consumer takes Q this cycle
//   Q          data of stage DEPTH-1
//   OCC        number of valid stages, 0..DEPTH
//
// Build option: define FF_D_PIPE_CLR_EN to zero the data registers on reset,
// on flush and whenever a stage loads a bubble, so that Q reads 0 while
// invalid. Without it only the valid bits are reset or cleared.

module ff_d_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCCW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Q,
  output logic [OCCW-1:0]  OCC
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] take_c;

  // Take chain, evaluated from the output end toward the input end.
  // A running variable avoids reading take_c back inside this block.
  always_comb begin
    logic t;
    take_c = '0;
    t      = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      t         = EN & ~FLUSH & ~RST & (~v_q[i] | t);
      take_c[i] = t;
    end
  end

  // Next-state for the valid bits and data of every stage.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    // Stage 0 loads from the input port.
    if (take_c[0]) begin
      v_d[0] = IN_VALID;
      if (IN_VALID) begin
        data_d[0] = D;
      end
`ifdef FF_D_PIPE_CLR_EN
      else begin
        data_d[0] = '0;
      end
`endif
    end

    // Later stages load from the stage upstream of them.
    for (int i = 1; i < DEPTH; i++) begin
      if (take_c[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
`ifdef FF_D_PIPE_CLR_EN
        else begin
          data_d[i] = '0;
        end
`endif
      end
    end

    // Flush drops everything in flight; the take chain is already gated off.
    if (FLUSH) begin
      v_d = '0;
`ifdef FF_D_PIPE_CLR_EN
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
`endif
    end
  end

  // Valid bits: always reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

`ifdef FF_D_PIPE_CLR_EN
  // Data registers with reset to zero.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST) begin
        data_q[i] <= '0;
      end else begin
        data_q[i] <= data_d[i];
      end
    end
  end
`else
  // Data registers without reset; stale contents are masked by v_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      data_q[i] <= data_d[i];
    end
  end
`endif

  // Occupancy: popcount of the registered valid bits.
  always_comb begin
    logic [OCCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCCW'(v_q[i]);
    end
    OCC = cnt;
  end

  assign IN_READY  = take_c[0];
  assign OUT_VALID = v_q[DEPTH-1];
  assign Q         = data_q[DEPTH-1];

endmodule

// File: tb/tb_ff_d_pipe.sv
// tb_ff_d_pipe: directed bench for ff_d_pipe (WIDTH = 32, DEPTH = 4).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 time unit later, well away from the active edge.

module tb_ff_d_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCCW  = $clog2(DEPTH + 1);

  logic             CLK;
  logic             RST;
  logic             EN;
  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] D;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Q;
  logic [OCCW-1:0]  OCC;

  int n_assert;
  int n_fail;

  ff_d_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .D         (D),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q),
    .OCC       (OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and move off it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    RST       = 1'b1;
    EN        = 1'b1;
    FLUSH     = 1'b0;
    IN_VALID  = 1'b1;
    D         = 32'h8000_0001;
    OUT_READY = 1'b0;

    // Reset held for two edges with a word offered.
    step();
    step();
    settle();
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_occ",       64'(OCC),       64'd0);
    check("rst_in_ready",  64'(IN_READY),  64'd0);
`ifdef FF_D_PIPE_CLR_EN
    check("rst_q",         64'(Q),         64'h0);
`endif

    // Latency / streaming: three words back to back, consumer always ready.
    RST       = 1'b0;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    D         = 32'h8000_0001;
    settle();
    check("stream_in_ready", 64'(IN_READY), 64'd1);
    step();
    check("stream_occ_e0", 64'(OCC), 64'd1);
    D = 32'h8000_0007;
    step();
    check("stream_occ_e1", 64'(OCC), 64'd2);
    D = 32'h0000_0003;
    step();
    check("stream_occ_e2", 64'(OCC), 64'd3);
    check("stream_ov_e2",  64'(OUT_VALID), 64'd0);
    IN_VALID = 1'b0;
    step();
    check("stream_ov_e3", 64'(OUT_VALID), 64'd1);
    check("stream_q_e3",  64'(Q),         64'h8000_0001);
    check("stream_occ_e3", 64'(OCC),      64'd3);
    step();
    check("stream_q_e4",  64'(Q),         64'h8000_0007);
    check("stream_occ_e4", 64'(OCC),      64'd2);
    step();
    check("stream_q_e5",  64'(Q),         64'h0000_0003);
    check("stream_occ_e5", 64'(OCC),      64'd1);
    step();
    check("stream_ov_e6", 64'(OUT_VALID), 64'd0);
    check("stream_occ_e6", 64'(OCC),      64'd0);

    // Fill under stall: five words offered, only four fit.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 32'h0000_0010 + 32'(i);
      settle();
      check("fill_in_ready", 64'(IN_READY), 64'd1);
      step();
    end
    D = 32'h0000_0014;
    settle();
    check("fill_full_in_ready", 64'(IN_READY), 64'd0);
    check("fill_full_occ",      64'(OCC),      64'd4);
    check("fill_full_q",        64'(Q),        64'h0000_0010);
    step();
    check("fill_hold_occ", 64'(OCC), 64'd4);
    check("fill_hold_q",   64'(Q),   64'h0000_0010);
    // Full with consumer ready: the whole chain opens.
    OUT_READY = 1'b1;
    settle();
    check("full_ready_in_ready", 64'(IN_READY), 64'd1);
    IN_VALID = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_q",   64'(Q),   64'h0000_0010 + 64'(i));
      check("drain_occ", 64'(OCC), 64'(4 - i));
    end
    step();
    check("drain_end_ov",  64'(OUT_VALID), 64'd0);
    check("drain_end_occ", 64'(OCC),       64'd0);

    // Bubble collapse: word, two idle cycles, word, output stalled.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    D         = 32'hA000_0001;
    step();
    IN_VALID = 1'b0;
    step();
    step();
    IN_VALID = 1'b1;
    D        = 32'hA000_0002;
    step();
    IN_VALID = 1'b0;
    step();
    step();
    check("bubble_occ", 64'(OCC),       64'd2);
    check("bubble_ov",  64'(OUT_VALID), 64'd1);
    check("bubble_q",   64'(Q),         64'hA000_0001);
    check("bubble_v",   64'(dut.v_q),   64'b1100);

    // EN freeze with two words held while both ends are willing.
    EN        = 1'b0;
    IN_VALID  = 1'b1;
    D         = 32'hDEAD_BEEF;
    OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("freeze_in_ready", 64'(IN_READY),  64'd0);
      check("freeze_ov",       64'(OUT_VALID), 64'd1);
      check("freeze_q",        64'(Q),         64'hA000_0001);
      check("freeze_occ",      64'(OCC),       64'd2);
      step();
    end
    check("freeze_end_occ", 64'(OCC), 64'd2);
    check("freeze_end_q",   64'(Q),   64'hA000_0001);
    EN       = 1'b1;
    IN_VALID = 1'b0;
    step();
    check("unfreeze_q",   64'(Q),   64'hA000_0002);
    check("unfreeze_occ", 64'(OCC), 64'd1);
    step();
    check("unfreeze_ov",  64'(OUT_VALID), 64'd0);
    check("unfreeze_occ_end", 64'(OCC),   64'd0);

    // Flush with three words in flight and a word offered.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = 32'hC000_0000 + 32'(i);
      step();
    end
    check("preflush_occ", 64'(OCC), 64'd3);
    FLUSH     = 1'b1;
    OUT_READY = 1'b1;
    D         = 32'hC000_0003;
    settle();
    check("flush_in_ready", 64'(IN_READY), 64'd0);
    step();
    check("flush_occ", 64'(OCC),       64'd0);
    check("flush_ov",  64'(OUT_VALID), 64'd0);
`ifdef FF_D_PIPE_CLR_EN
    check("flush_q",   64'(Q),         64'h0);
`endif
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("postflush_occ", 64'(OCC), 64'd0);
    end

    // Pipeline still usable after flush.
    IN_VALID = 1'b1;
    D        = 32'h1234_5678;
    step();
    IN_VALID = 1'b0;
    step();
    step();
    step();
    check("postflush_ov", 64'(OUT_VALID), 64'd1);
    check("postflush_q",  64'(Q),         64'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
